// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the two RAM requesters, the arbiter and the RAM macro.
// slave: arbiter side. master: requester/RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_done;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_rdata, ldr_done,
    output ram_addr, ram_wdata, ram_we, ram_re,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_rdata, ldr_done,
    input  ram_addr, ram_wdata, ram_we, ram_re,
    output ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares a single-port synchronous RAM between the CPU control unit and the loader port.
// Ports: clk, Reset (sync, active-high), port (mem_port_arbiter_if.slave: cpu_*, ldr_*, ram_*),
//        busy (state != IDLE), grant_id (0 = CPU, 1 = loader; current/most recent owner).
// MEM_ARB_RR_EN defined: round-robin on ties; undefined: CPU wins ties.
module mem_port_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 Reset,
  mem_port_arbiter_if.slave    port,
  output logic                 busy,
  output logic                 grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        lat_q, lat_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic              pick_ldr;
`ifdef MEM_ARB_RR_EN
  logic              last_grant_q, last_grant_d;
`endif

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    grant_d     = grant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    pick_ldr    = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (port.cpu_req || port.ldr_req) begin
`ifdef MEM_ARB_RR_EN
          if (port.cpu_req && port.ldr_req) pick_ldr = ~last_grant_q;
          else                              pick_ldr = port.ldr_req;
          last_grant_d = pick_ldr;
`else
          pick_ldr = ~port.cpu_req;
`endif
          grant_d = pick_ldr;
          we_d    = pick_ldr ? port.ldr_we    : port.cpu_we;
          addr_d  = pick_ldr ? port.ldr_addr  : port.cpu_addr;
          wdata_d = pick_ldr ? port.ldr_wdata : port.cpu_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          lat_d   = 3'(RAM_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        lat_d = lat_q - 3'd1;
        // ram_rdata is valid in the last WAIT cycle, so the owner's register updates with done.
        if (lat_q == 3'd1) begin
          if (grant_q) ldr_rdata_d = port.ram_rdata;
          else         cpu_rdata_d = port.ram_rdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      grant_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign port.ram_addr  = addr_q;
  assign port.ram_wdata = wdata_q;
  assign port.ram_we    = (state_q == ISSUE) &&  we_q;
  assign port.ram_re    = (state_q == ISSUE) && !we_q;
  assign port.cpu_done  = (state_q == DONE) && !grant_q;
  assign port.ldr_done  = (state_q == DONE) &&  grant_q;
  assign port.cpu_rdata = cpu_rdata_q;
  assign port.ldr_rdata = ldr_rdata_q;
  assign busy           = (state_q != IDLE);
  assign grant_id       = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural RAM and a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic Reset;
  logic busy, grant_id;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(LAT)) dut (
    .clk(clk), .Reset(Reset), .port(bus.slave), .busy(busy), .grant_id(grant_id)
  );

  // RAM environment: read data appears LAT cycles after ram_re, junk otherwise.
  logic [31:0] ram  [512];
  logic [31:0] pipe [LAT];
  assign bus.ram_rdata = pipe[LAT-1];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    pipe[0] <= bus.ram_re ? ram[bus.ram_addr] : 32'hBADC0FFE;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  // Reference model state
  logic [31:0] ref_mem [512];
  logic [31:0] exp_rd  [2];
  bit          lg;
  int          errors = 0;
  int          checks = 0;

  typedef struct { bit who; bit we; logic [8:0] addr; logic [31:0] wdata; } txn_t;
  typedef struct { bit who; bit we; logic [8:0] addr; logic [31:0] wdata; logic [31:0] exp_rd; } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic int dur(input bit we);
    return we ? 2 : 2 + LAT;
  endfunction

  task automatic drive(input txn_t t);
    if (!t.who) begin
      bus.cpu_req = 1'b1; bus.cpu_we = t.we; bus.cpu_addr = t.addr; bus.cpu_wdata = t.wdata;
    end else begin
      bus.ldr_req = 1'b1; bus.ldr_we = t.we; bus.ldr_addr = t.addr; bus.ldr_wdata = t.wdata;
    end
  endtask

  task automatic scramble(input bit who);
    if (!who) begin
      bus.cpu_addr = 9'($urandom); bus.cpu_wdata = $urandom; bus.cpu_we = 1'($urandom);
    end else begin
      bus.ldr_addr = 9'($urandom); bus.ldr_wdata = $urandom; bus.ldr_we = 1'($urandom);
    end
  endtask

  task automatic chk_rdata();
    chk("cpu_rdata", bus.cpu_rdata, exp_rd[0]);
    chk("ldr_rdata", bus.ldr_rdata, exp_rd[1]);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after the last done.
  task automatic run_pair(input bit c_on, input txn_t ct, input bit l_on, input txn_t lt);
    txn_t first, second, t;
    bit   two, act, dn;
    int   d1, s2, e_end, o;
    ct.who = 1'b0;
    lt.who = 1'b1;
    two = c_on && l_on;
    first = c_on ? ct : lt;
    second = lt;
`ifdef MEM_ARB_RR_EN
    if (two && !lg) begin first = lt; second = ct; end
`endif
    d1    = dur(first.we);
    s2    = d1 + 1;
    e_end = two ? s2 + dur(second.we) : d1;
    if (c_on) drive(ct);
    if (l_on) drive(lt);
    for (int c = 1; c <= e_end + 1; c++) begin
      @(posedge clk); #1;
      if (c == 1) scramble(first.who);
      if (two && c == s2 + 1) scramble(second.who);
      @(negedge clk);
      act = 1'b0; o = 0; t = first;
      if (c <= d1) begin act = 1'b1; t = first; o = c; end
      else if (two && c >= s2 + 1 && c <= e_end) begin act = 1'b1; t = second; o = c - s2; end
      dn = act && (o == dur(t.we));
      if (act && o == 1 && t.we) ref_mem[t.addr] = t.wdata;
      if (dn && !t.we) exp_rd[t.who] = ref_mem[t.addr];
      chk("busy", busy, act);
      chk("ram_we", bus.ram_we, act && o == 1 && t.we);
      chk("ram_re", bus.ram_re, act && o == 1 && !t.we);
      chk("cpu_done", bus.cpu_done, dn && !t.who);
      chk("ldr_done", bus.ldr_done, dn && t.who);
      chk("grant_id", grant_id, (two && c >= s2 + 1) ? second.who : first.who);
      if (act && o == 1) chk("ram_addr", bus.ram_addr, t.addr);
      if (act && o == 1 && t.we) chk("ram_wdata", bus.ram_wdata, t.wdata);
      chk_rdata();
      if (dn) begin
        if (t.who) bus.ldr_req = 1'b0;
        else       bus.cpu_req = 1'b0;
      end
    end
    lg = two ? second.who : first.who;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_grant"}, grant_id, 1'b0);
    chk({nm, "_ram_we"}, bus.ram_we, 1'b0);
    chk({nm, "_ram_re"}, bus.ram_re, 1'b0);
    chk({nm, "_ram_addr"}, bus.ram_addr, 32'h0);
    chk({nm, "_ram_wdata"}, bus.ram_wdata, 32'h0);
    chk({nm, "_cpu_done"}, bus.cpu_done, 1'b0);
    chk({nm, "_ldr_done"}, bus.ldr_done, 1'b0);
    chk({nm, "_cpu_rdata"}, bus.cpu_rdata, 32'h0);
    chk({nm, "_ldr_rdata"}, bus.ldr_rdata, 32'h0);
  endtask

  initial begin
    vec_t tbl [8];
    txn_t a, b;
    bit   own [3];
    int   dc  [3];
    bit   cd, ld;
    int   mode;

    tbl = '{
      '{1'b0, 1'b1, 9'h012, 32'hDEADBEEF, 32'h0},
      '{1'b0, 1'b0, 9'h012, 32'h0,        32'hDEADBEEF},
      '{1'b1, 1'b1, 9'h1FF, 32'hFFFFFFFF, 32'h0},
      '{1'b1, 1'b0, 9'h1FF, 32'h0,        32'hFFFFFFFF},
      '{1'b0, 1'b0, 9'h1FF, 32'h0,        32'hFFFFFFFF},
      '{1'b1, 1'b1, 9'h000, 32'h00000000, 32'h0},
      '{1'b1, 1'b0, 9'h000, 32'h0,        32'h00000000},
      '{1'b0, 1'b0, 9'h012, 32'h0,        32'hDEADBEEF}
    };
    for (int i = 0; i < 512; i++) begin
      ram[i]     = 32'hC0DE0000 | 32'(i);
      ref_mem[i] = 32'hC0DE0000 | 32'(i);
    end
    for (int i = 0; i < LAT; i++) pipe[i] = 32'h0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; lg = 1'b1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;

    Reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    Reset = 1'b0;

    // Directed single transactions
    for (int i = 0; i < 8; i++) begin
      a = '{tbl[i].who, tbl[i].we, tbl[i].addr, tbl[i].wdata};
      run_pair(!tbl[i].who, a, tbl[i].who, a);
      if (!tbl[i].we) chk($sformatf("tbl%0d_rdata", i), tbl[i].who ? bus.ldr_rdata : bus.cpu_rdata, tbl[i].exp_rd);
    end

    // Simultaneous reads, each dropped after its own done
    a = '{1'b0, 1'b0, 9'h012, 32'h0};
    b = '{1'b1, 1'b0, 9'h1FF, 32'h0};
    run_pair(1'b1, a, 1'b1, b);

    // Both requests held through three services
`ifdef MEM_ARB_RR_EN
    own[0] = !lg; own[1] = lg; own[2] = !lg;
`else
    own[0] = 1'b0; own[1] = 1'b0; own[2] = 1'b0;
`endif
    for (int k = 0; k < 3; k++) dc[k] = (k + 1) * (2 + LAT) + k;
    drive(a);
    drive(b);
    for (int c = 1; c <= dc[2] + 1; c++) begin
      @(negedge clk);
      cd = 1'b0; ld = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (c == dc[k]) begin
          if (own[k]) begin ld = 1'b1; exp_rd[1] = ref_mem[9'h1FF]; end
          else        begin cd = 1'b1; exp_rd[0] = ref_mem[9'h012]; end
        end
      end
      chk("hold_cpu_done", bus.cpu_done, cd);
      chk("hold_ldr_done", bus.ldr_done, ld);
      chk_rdata();
      if (c == dc[2]) begin bus.cpu_req = 1'b0; bus.ldr_req = 1'b0; end
    end
    lg = own[2];

    // Loader back-to-back writes with req held through done
    drive('{1'b1, 1'b1, 9'h000, 32'h11110000});
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("b2b_ram_we", bus.ram_we, c == 1 || c == 4 || c == 7);
      chk("b2b_ldr_done", bus.ldr_done, c == 2 || c == 5 || c == 8);
      chk("b2b_cpu_done", bus.cpu_done, 1'b0);
      if (c % 3 == 1 && c < 9) begin
        chk("b2b_ram_addr", bus.ram_addr, 32'((c - 1) / 3));
        chk("b2b_ram_wdata", bus.ram_wdata, 32'h11110000 + 32'((c - 1) / 3));
        ref_mem[(c - 1) / 3] = 32'h11110000 + 32'((c - 1) / 3);
      end
      if (c == 2 || c == 5) begin
        bus.ldr_addr  = 9'((c + 1) / 3);
        bus.ldr_wdata = 32'h11110000 + 32'((c + 1) / 3);
      end
      if (c == 8) bus.ldr_req = 1'b0;
    end
    chk("b2b_idle", busy, 1'b0);
    lg = 1'b1;

    // Reset during the WAIT phase of a CPU read
    drive('{1'b0, 1'b0, 9'h012, 32'h0});
    @(negedge clk);
    @(negedge clk);
    chk("rst_wait_busy", busy, 1'b1);
    chk("rst_wait_re", bus.ram_re, 1'b0);
    Reset = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    Reset = 1'b0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; lg = 1'b1;
    run_pair(1'b1, '{1'b0, 1'b1, 9'h055, 32'hCAFEF00D}, 1'b0, a);
    run_pair(1'b0, a, 1'b1, '{1'b1, 1'b0, 9'h055, 32'h0});
    chk("post_rst_rd", bus.ldr_rdata, 32'hCAFEF00D);

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      a = '{1'b0, 1'($urandom), ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom_range(0, 15)), $urandom};
      b = '{1'b1, 1'($urandom), ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom_range(0, 15)), $urandom};
      run_pair(mode != 1, a, mode != 0, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
